dac_sigma_delta: RTL and testbench

//   10-bit DAC front end, the output counterpart of the ADC model: accepts

---
 rtl/dac_sigma_delta.sv | 106 ++++++++++
 tb/tb_dac_sigma_delta.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/dac_sigma_delta.sv
// First-order sigma-delta DAC front end with valid/ready code intake and a settle flag; optional slew limiter under DAC_SLEW_LIMIT_EN.
// Latency: handshake edge -> dac_code 1 cycle, dac_code -> dac_bit 1 cycle.
// Backpressure: din_ready low while OFF, while enable=0, or while dac_code is still moving toward target.
module dac_sigma_delta #(
    parameter int WIDTH         = 10,
    parameter int SETTLE_CYCLES = 64,
    parameter int SLEW_STEP     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic [WIDTH-1:0] dac_code,
    output logic             dac_bit,
    output logic             settled,
    output logic             busy
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);

`ifdef DAC_SLEW_LIMIT_EN
    localparam logic [WIDTH-1:0] STEP_LIM = WIDTH'(SLEW_STEP);
`else
    // A full-scale step limit turns the slew path into a one-cycle jump; SLEW_STEP has no effect here.
    localparam logic [WIDTH-1:0] STEP_LIM = WIDTH'((2 ** WIDTH) - 1 + 0 * SLEW_STEP);
`endif

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_RUN = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] code_q, code_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             bit_q, bit_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             run_act;
    logic             up;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] step;
    logic [WIDTH:0]   sum;

    always_comb begin
        state_d   = enable ? ST_RUN : ST_OFF;
        run_act   = (state_q == ST_RUN) && enable;
        busy      = (target_q != code_q);
        din_ready = (state_q == ST_RUN) && enable && !busy;
        settled   = (state_q == ST_RUN) && !busy && (cnt_q == CW'(SETTLE_CYCLES));

        target_d = (din_valid && din_ready) ? din : target_q;

        up   = (target_q >= code_q);
        diff = up ? (target_q - code_q) : (code_q - target_q);
        step = (diff > STEP_LIM) ? STEP_LIM : diff;

        code_d = code_q;
        if (run_act) begin
            code_d = up ? (code_q + step) : (code_q - step);
        end

        // Carry out of the accumulator is the output bit; wrap is intentional.
        sum   = {1'b0, acc_q} + {1'b0, code_q};
        acc_d = acc_q;
        bit_d = bit_q;
        cnt_d = cnt_q;
        if (!enable) begin
            acc_d = '0;
            bit_d = 1'b0;
            cnt_d = '0;
        end else if (run_act) begin
            acc_d = sum[WIDTH-1:0];
            bit_d = sum[WIDTH];
            if (code_d != code_q) begin
                cnt_d = '0;
            end else if (cnt_q != CW'(SETTLE_CYCLES)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            target_q <= '0;
            code_q   <= '0;
            acc_q    <= '0;
            bit_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            target_q <= target_d;
            code_q   <= code_d;
            acc_q    <= acc_d;
            bit_q    <= bit_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dac_code = code_q;
    assign dac_bit  = bit_q;

endmodule

// File: tb/tb_dac_sigma_delta.sv
// Directed plus randomized bench for dac_sigma_delta against a cycle model and density/settle-time arithmetic.
module tb_dac_sigma_delta;
    localparam int W      = 10;
    localparam int FULL   = 1 << W;
    localparam int SETTLE = 64;
`ifdef DAC_SLEW_LIMIT_EN
    localparam int STEP = 8;
`else
    localparam int STEP = FULL;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [W-1:0] dac_code;
    logic         dac_bit;
    logic         settled;
    logic         busy;

    int total = 0;
    int passed = 0;
    int failed = 0;

    // Reference state, plain integers
    bit m_run;
    int m_target, m_code, m_acc, m_bit, m_since;
    bit last_accept;

    dac_sigma_delta #(.WIDTH(W), .SETTLE_CYCLES(SETTLE), .SLEW_STEP(8)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .dac_code(dac_code), .dac_bit(dac_bit),
        .settled(settled), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_target = 0; m_code = 0; m_acc = 0; m_bit = 0; m_since = 0;
    endtask

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    // One clock: check ready before the edge, advance the model, check outputs after it.
    task automatic tick();
        bit ready, active;
        int ncode, s;
        #1;
        ready  = m_run && enable && (m_target == m_code);
        chk("din_ready", {31'd0, din_ready}, {31'd0, ready});
        last_accept = din_valid && ready;
        active = m_run && enable;
        ncode = m_code;
        if (active) begin
            if (m_target > m_code) ncode = m_code + imin(STEP, m_target - m_code);
            else                   ncode = m_code - imin(STEP, m_code - m_target);
        end
        if (!enable) begin
            m_acc = 0; m_bit = 0; m_since = 0;
        end else if (active) begin
            s       = m_acc + m_code;
            m_bit   = (s >= FULL) ? 1 : 0;
            m_acc   = s % FULL;
            m_since = (ncode != m_code) ? 0 : imin(m_since + 1, SETTLE);
        end
        m_code = ncode;
        if (last_accept) m_target = int'(din);
        m_run = enable;
        @(posedge clk);
        #1;
        chk("dac_code", {22'd0, dac_code}, m_code);
        chk("dac_bit", {31'd0, dac_bit}, m_bit);
        chk("busy", {31'd0, busy}, (m_target != m_code) ? 1 : 0);
        chk("settled", {31'd0, settled},
            (m_run && m_target == m_code && m_since == SETTLE) ? 1 : 0);
    endtask

    task automatic send(input int code);
        int n;
        din = W'(code);
        din_valid = 1'b1;
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_accept && n < 40);
        din_valid = 1'b0;
        if (!last_accept) chk("send_timeout", 0, 1);
        tick();
    endtask

    task automatic run_window(input int n, output int ones, output int rise);
        ones = 0;
        rise = 0;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (dac_bit === 1'b1) ones++;
            if (rise == 0 && settled === 1'b1) rise = i;
        end
    endtask

    initial begin
        int ones, rise;
        bit pending;

        model_reset();
        #22;
        chk("rst_code", {22'd0, dac_code}, 0);
        chk("rst_bit", {31'd0, dac_bit}, 0);
        chk("rst_settled", {31'd0, settled}, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_ready", {31'd0, din_ready}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Mid-scale: half density, settle after SETTLE cycles
        enable = 1'b1;
        tick();
        send(12'h200);
        chk("code_200", {22'd0, dac_code}, 12'h200);
        run_window(FULL, ones, rise);
        chk("ones_200", ones, 512);
        chk("rise_200", rise, SETTLE);

        // Full-scale extremes
        send(0);
        run_window(FULL, ones, rise);
        chk("ones_000", ones, 0);
        send(12'h3FF);
        run_window(FULL, ones, rise);
        chk("ones_3ff", ones, 1023);

        // Disabled: no transfer, output low, restart from zero accumulator
        enable = 1'b0;
        din = W'(12'h0AA);
        din_valid = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("off_code", {22'd0, dac_code}, 12'h3FF);
        chk("off_bit", {31'd0, dac_bit}, 0);
        chk("off_ready", {31'd0, din_ready}, 0);
        din_valid = 1'b0;
        enable = 1'b1;
        tick();
        run_window(100, ones, rise);
        chk("restart_ones", ones, (100 * 1023) / FULL);
        chk("restart_rise", rise, SETTLE);

        // Resending the current code keeps settled high
        send(12'h155);
        run_window(100, ones, rise);
        chk("rise_155", rise, SETTLE);
        send(12'h155);
        chk("resend_settled", {31'd0, settled}, 1);
        tick();
        chk("resend_settled2", {31'd0, settled}, 1);

`ifdef DAC_SLEW_LIMIT_EN
        send(0);
        run_window(80, ones, rise);
        din = W'(12'h064);
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            chk("slew_busy", {31'd0, busy}, 1);
            tick();
            chk("slew_code", {22'd0, dac_code}, imin(8 * i, 100));
        end
        run_window(80, ones, rise);
        chk("slew_rise", rise, SETTLE);
`endif

        // Randomized traffic with occasional enable drops
        pending = 0;
        for (int i = 0; i < 3000; i++) begin
            enable = ($urandom_range(0, 19) != 0);
            if (!pending && $urandom_range(0, 7) == 0) begin
                din = W'($urandom);
                din_valid = 1'b1;
                pending = 1;
            end
            tick();
            if (last_accept) begin
                din_valid = 1'b0;
                pending = 0;
            end
        end
        din_valid = 1'b0;
        enable = 1'b1;
        tick();

        // Async reset in the middle of a running mid-scale code
        send(12'h200);
        for (int i = 0; i < 10; i++) tick();
        chk("pre_rst_code", {22'd0, dac_code}, 12'h200);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_code", {22'd0, dac_code}, 0);
        chk("arst_bit", {31'd0, dac_bit}, 0);
        chk("arst_settled", {31'd0, settled}, 0);
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_ready", {31'd0, din_ready}, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
